booth_mac_sequencer: RTL
========================

# booth_mac_sequencer

Multi-cycle signed multiply-accumulate controller for the NPU MAC unit. Accepts one operand pair per transaction, walks the multiplier two bits per cycle through a radix-4 Booth encoder, and adds each selected partial product (0, ±A, ±2A, shifted) into a persistent accumulator. The block replaces a full parallel multiplier array in area-constrained MAC lanes and returns the accumulated result on a valid/ready output.

## Interface
- WIDTH, 8: operand width in bits, signed two's complement; must be even and ≥ 4
- ACC_W, 32: accumulator width; must be ≥ 2*WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  multiplicand, signed
- b  in  WIDTH  multiplier, signed
- acc_clear  in  1  sampled with the operands; zero the accumulator before this product
- out_valid  out  1  acc_out holds a completed result
- out_ready  in  1  consumer accepts result
- acc_out  out  ACC_W  accumulator value, signed
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch a (sign-extended to ACC_W) and b, extended with an implicit b[-1]=0; load accumulator with 0 if acc_clear else keep it; step counter i=0; go RUN.
- RUN: each cycle encode triplet {b[2i+1], b[2i], b[2i-1]}:
  - 000/111 → zero; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - Partial product = (zero ? 0 : shift ? A<<1 : A), negated when negation set, then shifted left by 2i, all at ACC_W bits.
  - acc ← acc + partial product, modulo 2^ACC_W (wrap, no saturation, no overflow flag).
  - i increments; after step i=WIDTH/2−1 go DONE.
- DONE: out_valid=1, acc_out stable. On out_ready go IDLE. The block never accepts new operands in the same cycle as the result handshake.
- acc_out always reflects the accumulator register; it is only meaningful while out_valid=1.
- Inputs a, b, acc_clear are ignored outside the accept cycle.

## Timing
- Reset (any state, including mid-RUN): state=IDLE, accumulator=0, counter=0; outputs after the reset edge: in_ready=1, out_valid=0, busy=0, acc_out=0. Partial work is discarded.
- Accept at edge E0 → RUN during cycles following E0 through E(WIDTH/2−1); state=DONE after edge E(WIDTH/2). For WIDTH=8: out_valid high 4 edges after accept.
- out_valid held indefinitely while out_ready=0; acc_out unchanged.
- Result handshake at edge Ek → in_ready=1 from the cycle after Ek; minimum issue interval WIDTH/2+2 cycles.
- in_valid asserted during RUN/DONE has no effect and is not consumed.
- Registered outputs only; no combinational path from in_valid or out_ready to any output except none (in_ready, out_valid, busy are state decodes).

## Structure
- Package booth_mac_pkg: state enum (IDLE, RUN, DONE), step-count width function clog2(WIDTH/2), encoding constants for zero/shift/negation.
- Sub-module booth_radix4_encode: combinational 3-bit triplet → shift, negation, zero; instantiated once, fed by a counter-selected mux of b.
- Parameter checks (WIDTH even, ACC_W ≥ 2*WIDTH) as elaboration-time assertions.

## Test plan
- WIDTH=8, ACC_W=32: a=7, b=3, acc_clear=1 → out_valid after 4 cycles, acc_out=21.
- Follow with a=−5, b=4, acc_clear=0 → acc_out=1; then a=−128, b=−128, acc_clear=1 → acc_out=16384.
- Result backpressure: out_ready=0 for 5 cycles in DONE → out_valid, acc_out stable, in_ready=0, extra in_valid pulses not consumed; out_ready=1 → in_ready=1 next cycle.
- rst asserted in second RUN cycle of a=100, b=−50 → next cycle in_ready=1, out_valid=0, acc_out=0; subsequent a=2, b=2, acc_clear=0 → acc_out=4.
- ACC_W=16: three back-to-back a=127, b=127 (first with acc_clear=1) → 16129, 32258, −17149 (wrap).
- Exhaustive WIDTH=4: all 256 (a,b) pairs with acc_clear=1 → acc_out equals a*b sign-extended, latency exactly 2 cycles each.

Source files
------------

// File: rtl/booth_mac_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply-accumulate sequencer.
//   state_e     : sequencer states (idle, stepping through the multiplier, result held)
//   booth_sel_t : partial-product select {zero, shift, neg} produced by the encoder
//   step_w()    : width of the step counter for a given operand width
package booth_mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // zero: contribute nothing; shift: use 2A instead of A; neg: subtract instead of add.
  typedef struct packed {
    logic zero;
    logic shift;
    logic neg;
  } booth_sel_t;

  localparam booth_sel_t BoothZero  = '{zero: 1'b1, shift: 1'b0, neg: 1'b0};
  localparam booth_sel_t BoothPosA  = '{zero: 1'b0, shift: 1'b0, neg: 1'b0};
  localparam booth_sel_t BoothPos2A = '{zero: 1'b0, shift: 1'b1, neg: 1'b0};
  localparam booth_sel_t BoothNegA  = '{zero: 1'b0, shift: 1'b0, neg: 1'b1};
  localparam booth_sel_t BoothNeg2A = '{zero: 1'b0, shift: 1'b1, neg: 1'b1};

  // Counter must hold 0 .. width/2-1; never narrower than one bit.
  function automatic int unsigned step_w(input int unsigned width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/booth_radix4_encode.sv
// Radix-4 Booth recoder: maps a multiplier triplet {b[2i+1], b[2i], b[2i-1]} to the
// partial-product select.
//   triplet in  3 : overlapping multiplier bits
//   zero    out 1 : partial product is zero
//   shift   out 1 : partial product magnitude is 2A (else A)
//   neg     out 1 : partial product is negated
module booth_radix4_encode
  import booth_mac_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       zero,
  output logic       shift,
  output logic       neg
);

  booth_sel_t sel;

  always_comb begin
    sel = BoothZero;
    unique case (triplet)
      3'b001, 3'b010: sel = BoothPosA;
      3'b011:         sel = BoothPos2A;
      3'b100:         sel = BoothNeg2A;
      3'b101, 3'b110: sel = BoothNegA;
      default:        sel = BoothZero;
    endcase
  end

  assign zero  = sel.zero;
  assign shift = sel.shift;
  assign neg   = sel.neg;

endmodule

// File: rtl/booth_mac_sequencer.sv
// Multi-cycle signed multiply-accumulate: one operand pair per transaction, multiplier
// consumed two bits per cycle via radix-4 Booth recoding, partial products summed into a
// persistent accumulator (wraps modulo 2^ACC_W).
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only while idle)
//   a, b                 : signed multiplicand / multiplier
//   acc_clear            : zero the accumulator before this product
//   out_valid / out_ready: result handshake; acc_out stable while out_valid
//   acc_out              : accumulator register
//   busy                 : transaction in progress or result pending
module booth_mac_sequencer
  import booth_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy
);

  localparam int unsigned     StepW    = step_w(WIDTH);
  localparam logic [StepW-1:0] LastStep = StepW'(WIDTH / 2 - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mac_sequencer: WIDTH must be even and at least 4");
  end
  if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
    $error("booth_mac_sequencer: ACC_W must be at least 2*WIDTH");
  end

  state_e           state_q;
  logic [ACC_W-1:0] a_q;
  logic [ACC_W-1:0] acc_q;
  logic [WIDTH:0]   b_q;      // multiplier with the implicit b[-1]=0 appended at bit 0
  logic [StepW-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH:0]   b_shifted;
  logic [2:0]       triplet;
  logic             pp_zero;
  logic             pp_shift;
  logic             pp_neg;
  logic [ACC_W-1:0] pp_mag;
  logic [ACC_W-1:0] pp_signed;
  logic [ACC_W-1:0] pp;

  // Because b[-1] sits at bit 0 of b_q, step i's triplet starts at bit 2i.
  always_comb begin
    b_shifted = b_q >> {cnt_q, 1'b0};
    triplet   = b_shifted[2:0];
  end

  booth_radix4_encode u_encode (
    .triplet (triplet),
    .zero    (pp_zero),
    .shift   (pp_shift),
    .neg     (pp_neg)
  );

  always_comb begin
    pp_mag = '0;
    if (!pp_zero) begin
      pp_mag = pp_shift ? (a_q << 1) : a_q;
    end
    pp_signed = pp_neg ? (~pp_mag + ACC_W'(1)) : pp_mag;
    pp        = pp_signed << {cnt_q, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= {{(ACC_W - WIDTH){a[WIDTH-1]}}, a};
            b_q        <= {b, 1'b0};
            if (acc_clear) begin
              acc_q <= '0;
            end
            cnt_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          acc_q <= acc_q + pp;
          cnt_q <= cnt_q + StepW'(1);
          if (cnt_q == LastStep) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          // Returning to idle first keeps result and next accept in separate cycles.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;

endmodule
